// File: rtl/hazard_unit_mc.sv
// Load-use / branch / memory-busy pipeline control for the 5-stage MIPS core; outputs are combinational (0 latency).
// MemBusy freezes everything and holds state; load-use bubbles last LOAD_LATENCY cycles; StallCycles saturates.
module hazard_unit_mc #(
  parameter int REG_W        = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  IFIDRegRs,
  input  logic [REG_W-1:0]  IFIDRegRt,
  input  logic              IFIDUsesRt,
  input  logic [REG_W-1:0]  IDEXRegRt,
  input  logic              IDEXMemRead,
  input  logic              BranchTaken,
  input  logic              MemBusy,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              Stall,
  output logic              IFIDFlush,
  output logic              IDEXFlush,
  output logic              Freeze,
  output logic [STAT_W-1:0] StallCycles
);

  typedef enum logic {IDLE, LSTALL} state_t;

  localparam logic [3:0]        CNT_INIT = 4'(LOAD_LATENCY - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              hz;

  assign hz = IDEXMemRead && (IDEXRegRt != '0) &&
              ((IDEXRegRt == IFIDRegRs) || (IFIDUsesRt && (IDEXRegRt == IFIDRegRt)));

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    Stall     = 1'b0;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    Freeze    = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (!rst_n) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      Stall     = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else if (MemBusy) begin
      // State and any pending branch are held; the branch input stays up until the freeze lifts.
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      Freeze    = 1'b1;
    end else if (BranchTaken) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else if (state_q == LSTALL) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      Stall     = 1'b1;
      cnt_d     = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = IDLE;
    end else if (hz) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      Stall     = 1'b1;
      if (LOAD_LATENCY > 1) begin
        state_d = LSTALL;
        cnt_d   = CNT_INIT;
      end
    end
  end

  always_comb begin
    stat_d = stat_q;
    if (!rst_n)                            stat_d = '0;
    else if (!PCWrite && stat_q != STAT_MAX) stat_d = stat_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    stat_q  <= stat_d;
  end

  assign StallCycles = stat_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: three instances (LOAD_LATENCY 1/3, STAT_W 16/4) share stimulus; a queue holds expected outputs.
module tb_hazard_unit_mc;

  typedef struct packed {
    logic       rstn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic [4:0] exrt;
    logic       mr;
    logic       br;
    logic       busy;
  } stim_t;

  typedef struct packed {
    logic [2:0]  sel;
    logic [5:0]  ctl;
    logic [15:0] stat;
  } exp_t;

  // ctl = {PCWrite, IFIDWrite, Stall, IFIDFlush, IDEXFlush, Freeze}
  localparam logic [5:0] C_NORM  = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b001000;
  localparam logic [5:0] C_FRZ   = 6'b000001;
  localparam logic [5:0] C_BR    = 6'b110110;

  localparam stim_t S_NOP = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, exrt;
  logic       uses, mr, br, busy;

  logic        pcw1, ifw1, stl1, iff1, idf1, frz1;
  logic        pcw3, ifw3, stl3, iff3, idf3, frz3;
  logic        pcw4, ifw4, stl4, iff4, idf4, frz4;
  logic [15:0] stat1, stat3;
  logic [3:0]  stat4;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_W(5), .LOAD_LATENCY(1), .STAT_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .IFIDRegRs(rs), .IFIDRegRt(rt), .IFIDUsesRt(uses),
    .IDEXRegRt(exrt), .IDEXMemRead(mr), .BranchTaken(br), .MemBusy(busy),
    .PCWrite(pcw1), .IFIDWrite(ifw1), .Stall(stl1), .IFIDFlush(iff1), .IDEXFlush(idf1),
    .Freeze(frz1), .StallCycles(stat1));

  hazard_unit_mc #(.REG_W(5), .LOAD_LATENCY(3), .STAT_W(16)) d3 (
    .clk(clk), .rst_n(rst_n), .IFIDRegRs(rs), .IFIDRegRt(rt), .IFIDUsesRt(uses),
    .IDEXRegRt(exrt), .IDEXMemRead(mr), .BranchTaken(br), .MemBusy(busy),
    .PCWrite(pcw3), .IFIDWrite(ifw3), .Stall(stl3), .IFIDFlush(iff3), .IDEXFlush(idf3),
    .Freeze(frz3), .StallCycles(stat3));

  hazard_unit_mc #(.REG_W(5), .LOAD_LATENCY(3), .STAT_W(4)) d4 (
    .clk(clk), .rst_n(rst_n), .IFIDRegRs(rs), .IFIDRegRt(rt), .IFIDUsesRt(uses),
    .IDEXRegRt(exrt), .IDEXMemRead(mr), .BranchTaken(br), .MemBusy(busy),
    .PCWrite(pcw4), .IFIDWrite(ifw4), .Stall(stl4), .IFIDFlush(iff4), .IDEXFlush(idf4),
    .Freeze(frz4), .StallCycles(stat4));

  function automatic logic [5:0] ctl_of(input logic [2:0] sel);
    case (sel)
      3'd1:    return {pcw1, ifw1, stl1, iff1, idf1, frz1};
      3'd3:    return {pcw3, ifw3, stl3, iff3, idf3, frz3};
      default: return {pcw4, ifw4, stl4, iff4, idf4, frz4};
    endcase
  endfunction

  function automatic logic [15:0] stat_of(input logic [2:0] sel);
    case (sel)
      3'd1:    return stat1;
      3'd3:    return stat3;
      default: return {12'd0, stat4};
    endcase
  endfunction

  task automatic drive(input stim_t s);
    rst_n = s.rstn; rs = s.rs; rt = s.rt; uses = s.uses;
    exrt = s.exrt;  mr = s.mr; br = s.br; busy = s.busy;
  endtask

  // Applies one stimulus row per cycle; the matching expectation is pushed with it and popped at the negedge.
  task automatic run_rows(input string name, input stim_t st[$], input exp_t ex[$]);
    exp_t e;
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (ctl_of(e.sel) !== e.ctl)
        $display("FAIL %s ctl cyc%0d dut%0d: got %b expected %b", name, i, e.sel, ctl_of(e.sel), e.ctl);
      else n_pass++;
      n_chk++;
      if (stat_of(e.sel) !== e.stat)
        $display("FAIL %s stat cyc%0d dut%0d: got %0d expected %0d", name, i, e.sel, stat_of(e.sel), e.stat);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    stim_t s;
    s = S_NOP; s.rstn = 1'b0;
    drive(s);
    @(posedge clk); #1;
    drive(S_NOP);
  endtask

  task automatic test_reset();
    stim_t s;
    s = S_NOP; s.rstn = 1'b0; s.busy = 1'b1; s.br = 1'b1;
    drive(s);
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      automatic logic [2:0] sel = (k == 0) ? 3'd1 : (k == 1) ? 3'd3 : 3'd4;
      n_chk++;
      if (ctl_of(sel) !== C_STALL)
        $display("FAIL reset_ctl dut%0d: got %b expected %b", sel, ctl_of(sel), C_STALL);
      else n_pass++;
      n_chk++;
      if (stat_of(sel) !== 16'd0)
        $display("FAIL reset_stat dut%0d: got %0d expected 0", sel, stat_of(sel));
      else n_pass++;
    end
    @(posedge clk); #1;
    drive(S_NOP);
  endtask

  task automatic test_single_bubble();
    stim_t st[$]; exp_t ex[$]; stim_t h;
    do_reset();
    h = S_NOP; h.mr = 1'b1; h.exrt = 5'd8; h.rs = 5'd8;
    st = '{h, S_NOP, S_NOP};
    ex = '{'{3'd1, C_STALL, 16'd0}, '{3'd1, C_NORM, 16'd1}, '{3'd1, C_NORM, 16'd1}};
    run_rows("single_bubble", st, ex);
  endtask

  task automatic test_filter();
    stim_t st[$]; exp_t ex[$]; stim_t a, b, c;
    do_reset();
    a = S_NOP; a.mr = 1'b1;                                          // $0 never hazards
    b = S_NOP; b.mr = 1'b1; b.exrt = 5'd9; b.rt = 5'd9; b.rs = 5'd3; // rt match but unused
    c = b;     c.uses = 1'b1;                                        // rt match and used
    st = '{a, b, c, S_NOP};
    ex = '{'{3'd1, C_NORM, 16'd0}, '{3'd1, C_NORM, 16'd0},
           '{3'd1, C_STALL, 16'd0}, '{3'd1, C_NORM, 16'd1}};
    run_rows("filter", st, ex);
  endtask

  task automatic test_multi_bubble();
    stim_t st[$]; exp_t ex[$]; stim_t h;
    do_reset();
    h = S_NOP; h.mr = 1'b1; h.exrt = 5'd5; h.rs = 5'd5;
    st = '{h, S_NOP, S_NOP, S_NOP, S_NOP};
    ex = '{'{3'd3, C_STALL, 16'd0}, '{3'd3, C_STALL, 16'd1}, '{3'd3, C_STALL, 16'd2},
           '{3'd3, C_NORM, 16'd3}, '{3'd3, C_NORM, 16'd3}};
    run_rows("multi_bubble", st, ex);
  endtask

  task automatic test_busy_in_stall();
    stim_t st[$]; exp_t ex[$]; stim_t h, m;
    do_reset();
    h = S_NOP; h.mr = 1'b1; h.exrt = 5'd5; h.rs = 5'd5;
    m = S_NOP; m.busy = 1'b1;
    st = '{h, m, m, S_NOP, S_NOP, S_NOP};
    ex = '{'{3'd3, C_STALL, 16'd0}, '{3'd3, C_FRZ, 16'd1}, '{3'd3, C_FRZ, 16'd2},
           '{3'd3, C_STALL, 16'd3}, '{3'd3, C_STALL, 16'd4}, '{3'd3, C_NORM, 16'd5}};
    run_rows("busy_in_stall", st, ex);
  endtask

  task automatic test_branch_cancel();
    stim_t st[$]; exp_t ex[$]; stim_t h, b;
    do_reset();
    h = S_NOP; h.mr = 1'b1; h.exrt = 5'd5; h.rs = 5'd5;
    b = S_NOP; b.br = 1'b1;
    st = '{h, b, S_NOP, S_NOP};
    ex = '{'{3'd3, C_STALL, 16'd0}, '{3'd3, C_BR, 16'd1},
           '{3'd3, C_NORM, 16'd1}, '{3'd3, C_NORM, 16'd1}};
    run_rows("branch_cancel", st, ex);
  endtask

  task automatic test_branch_busy();
    stim_t st[$]; exp_t ex[$]; stim_t bb, b;
    do_reset();
    b  = S_NOP; b.br = 1'b1;
    bb = b;     bb.busy = 1'b1;
    st = '{bb, bb, b, S_NOP};
    ex = '{'{3'd3, C_FRZ, 16'd0}, '{3'd3, C_FRZ, 16'd1},
           '{3'd3, C_BR, 16'd2}, '{3'd3, C_NORM, 16'd2}};
    run_rows("branch_busy", st, ex);
  endtask

  task automatic test_saturate();
    stim_t st[$]; exp_t ex[$]; stim_t m;
    do_reset();
    m = S_NOP; m.busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      st.push_back(m);
      ex.push_back('{3'd4, C_FRZ, 16'((k > 15) ? 15 : k)});
    end
    st.push_back(S_NOP);
    ex.push_back('{3'd4, C_NORM, 16'd15});
    run_rows("saturate", st, ex);
  endtask

  task automatic test_reset_mid_stall();
    stim_t st[$]; exp_t ex[$]; stim_t h, r;
    do_reset();
    h = S_NOP; h.mr = 1'b1; h.exrt = 5'd5; h.rs = 5'd5;
    r = S_NOP; r.rstn = 1'b0; r.busy = 1'b1;
    st = '{h, S_NOP, r, S_NOP, S_NOP};
    ex = '{'{3'd4, C_STALL, 16'd0}, '{3'd4, C_STALL, 16'd1}, '{3'd4, C_STALL, 16'd2},
           '{3'd4, C_NORM, 16'd0}, '{3'd4, C_NORM, 16'd0}};
    run_rows("reset_mid_stall", st, ex);
  endtask

  initial begin
    drive(S_NOP);
    rst_n = 1'b0;
    #1;
    test_reset();
    test_single_bubble();
    test_filter();
    test_multi_bubble();
    test_busy_in_stall();
    test_branch_cancel();
    test_branch_busy();
    test_saturate();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised hazard detection and pipeline-control unit for the 5-stage pipelined MIPS core. Successor to the single-cycle load-use stall unit.
- Supports load-use stalls of configurable length for multi-cycle data memory, with register $0 and unused-rt filtering.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Freezes the whole pipeline on a data-memory busy, and keeps a saturating stall-cycle counter for performance statistics.

Parameters:
- REG_W, 5, register-address width.
- LOAD_LATENCY, 1, bubble cycles inserted per load-use hazard (legal range 1..15).
- STAT_W, 16, width of the stall-cycle statistics counter.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  synchronous reset, active low.
- IFIDRegRs  input  REG_W  rs field of the instruction in ID.
- IFIDRegRt  input  REG_W  rt field of the instruction in ID.
- IFIDUsesRt  input  1  1 when the ID instruction reads rt as a source.
- IDEXRegRt  input  REG_W  destination rt of the instruction in EX.
- IDEXMemRead  input  1  instruction in EX is a load.
- BranchTaken  input  1  branch/jump resolved taken in EX this cycle.
- MemBusy  input  1  data memory cannot complete this cycle.
- PCWrite  output  1  PC load enable.
- IFIDWrite  output  1  IF/ID register load enable.
- Stall  output  1  insert bubble (zero controls) into ID/EX.
- IFIDFlush  output  1  clear IF/ID to NOP.
- IDEXFlush  output  1  clear ID/EX to NOP.
- Freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- StallCycles  output  STAT_W  saturating count of cycles with PCWrite=0.

Behaviour:
- State: FSM {IDLE, LSTALL}, down-counter cnt (4 bits), StallCycles register. All update on posedge clk only.
- Reset: while rst_n=0 at a clock edge, the next state is IDLE, cnt=0 and StallCycles=0. Outputs are combinational from state and inputs. While rst_n=0 the outputs are forced to PCWrite=0, IFIDWrite=0, Stall=1, IFIDFlush=0, IDEXFlush=0, Freeze=0. Reset asserted mid-stall abandons the stall; the first cycle after release is IDLE.
- Hazard term: hz = IDEXMemRead && IDEXRegRt!=0 && (IDEXRegRt==IFIDRegRs || (IFIDUsesRt && IDEXRegRt==IFIDRegRt)).
- Priority, highest first: MemBusy, then BranchTaken, then load stall (hz or state LSTALL), then normal.
- MemBusy=1:
  - Outputs: Freeze=1, PCWrite=0, IFIDWrite=0, Stall=0, both flushes 0.
  - State, cnt and a pending BranchTaken are all held; the flush fires on the first cycle with MemBusy=0.
  - StallCycles increments.
- BranchTaken=1 (MemBusy=0):
  - Outputs: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, Stall=0.
  - Next state is IDLE with cnt=0, cancelling any load stall because the stalled instruction is wrong-path.
- IDLE with hz=1:
  - Outputs: PCWrite=0, IFIDWrite=0, Stall=1. These are Mealy outputs, asserted in the detection cycle.
  - If LOAD_LATENCY>1, go to LSTALL with cnt=LOAD_LATENCY-1. Otherwise stay in IDLE, which is one-bubble behaviour.
- LSTALL:
  - Outputs: PCWrite=0, IFIDWrite=0, Stall=1, regardless of hz.
  - cnt decrements each non-frozen cycle. When cnt==1, the next state is IDLE.
  - Total bubbles per hazard is exactly LOAD_LATENCY.
- Normal: PCWrite=1, IFIDWrite=1, all other control outputs 0.
- StallCycles:
  - Increments by 1 on every cycle with rst_n=1 and PCWrite=0.
  - Saturates at 2^STAT_W-1 and never wraps.
- Invariant: Stall and IDEXFlush are never both 1.

Test Plan:
- LOAD_LATENCY=1, IDEXMemRead=1, IDEXRegRt=8, IFIDRegRs=8 for 1 cycle -> PCWrite=0, IFIDWrite=0, Stall=1 for exactly 1 cycle; StallCycles=1.
- IDEXRegRt=0 with IFIDRegRs=0 and IDEXMemRead=1 -> no stall. IDEXRegRt=9, IFIDRegRt=9, IFIDUsesRt=0 -> no stall.
- LOAD_LATENCY=3, hazard on reg 5 -> Stall=1 for 3 consecutive cycles, then PCWrite=1; StallCycles=3. Repeat with MemBusy=1 for 2 cycles during the 2nd bubble -> Freeze=1 for 2 cycles, then 2 more bubbles; StallCycles=5.
- LOAD_LATENCY=3, BranchTaken=1 in the 2nd bubble cycle -> IFIDFlush=IDEXFlush=1, PCWrite=1 that cycle; the next cycle is normal with no remaining bubbles.
- BranchTaken=1 together with MemBusy=1 for 2 cycles -> Freeze=1 and flushes 0 for 2 cycles; flushes=1 on the cycle MemBusy falls.
- STAT_W=4: 20 continuous MemBusy cycles -> StallCycles saturates at 15. rst_n=0 for 1 cycle mid LSTALL -> outputs forced as specified, then IDLE and StallCycles=0.
